// File: rtl/la_vdemux_pipe.sv
// rtl/la_vdemux_pipe.sv - one-hot select valid/ready demux with per-port output register
module la_vdemux_pipe #(
  parameter int    N    = 4,
  parameter int    W    = 8,
  parameter string PROP = "DEFAULT"
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [N-1:0]   in_sel,
  input  logic [W-1:0]   in_data,
  output logic           in_ready,
  output logic [N-1:0]   out_valid,
  output logic [W*N-1:0] out_data,
  input  logic [N-1:0]   out_ready,
  output logic           err,
  input  logic           err_clr,
  output logic [7:0]     drop_cnt
);

  logic [N-1:0] valid_q, valid_d;
  logic [W-1:0] data_q [N];
  logic [W-1:0] data_d [N];
  logic         err_q, err_d;
  logic [7:0]   cnt_q, cnt_d;

  logic         onehot;
  logic [N-1:0] free;
  logic [N-1:0] push;
  logic         drop;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign onehot = (in_sel != '0) && ((in_sel & (in_sel - N'(1))) == '0);
  assign free   = ~valid_q | out_ready;

  // With a one-hot select, the AND picks out free[k] without decoding k.
  assign in_ready = onehot ? |(in_sel & free) : 1'b1;

  assign push = (in_valid && onehot && in_ready) ? in_sel : '0;
  assign drop = in_valid && !onehot;

  always_comb begin
    valid_d = valid_q;
    for (int j = 0; j < N; j++) begin
      data_d[j] = data_q[j];
      if (push[j]) begin
        valid_d[j] = 1'b1;
        data_d[j]  = in_data;
      end else if (out_ready[j]) begin
        valid_d[j] = 1'b0;
      end
    end
  end

  // A drop in the same cycle as err_clr wins: the new event is recorded.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (drop) begin
      err_d = 1'b1;
      if (err_clr) begin
        cnt_d = 8'd1;
      end else if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (err_clr) begin
      err_d = 1'b0;
      cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
      for (int j = 0; j < N; j++) begin
        data_q[j] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      for (int j = 0; j < N; j++) begin
        data_q[j] <= data_d[j];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < N; j++) begin
      out_data[j*W +: W] = data_q[j];
    end
  end

  assign out_valid = valid_q;
  assign err       = err_q;
  assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_la_vdemux_pipe.sv
// tb/tb_la_vdemux_pipe.sv - randomized self-checking bench for la_vdemux_pipe
module tb_la_vdemux_pipe;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic [N-1:0]   in_sel;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic [N-1:0]   out_valid;
  logic [W*N-1:0] out_data;
  logic [N-1:0]   out_ready;
  logic           err;
  logic           err_clr;
  logic [7:0]     drop_cnt;

  la_vdemux_pipe #(.N(N), .W(W), .PROP("DEFAULT")) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sel(in_sel),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .err(err),
    .err_clr(err_clr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: each port is a one-entry slot holding either nothing or one beat.
  bit m_full [N];
  int m_data [N];
  bit m_err;
  int m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      m_full[j] = 0;
      m_data[j] = 0;
    end
    m_err = 0;
    m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] ev;
    for (int j = 0; j < N; j++) begin
      ev[j] = m_full[j];
      check($sformatf("%s.data%0d", tag, j), 64'(out_data[j*W +: W]), 64'(m_data[j]));
    end
    check({tag, ".valid"}, 64'(out_valid), 64'(ev));
    check({tag, ".err"}, 64'(err), 64'(m_err));
    check({tag, ".cnt"}, 64'(drop_cnt), 64'(m_cnt));
  endtask

  // Drive one cycle of inputs, check in_ready before the edge, then check state after it.
  task automatic step(input string tag, input logic v, input logic [N-1:0] s,
                      input logic [W-1:0] d, input logic [N-1:0] r, input logic c);
    int  ones;
    int  k;
    bit  exp_rdy;
    in_valid = v; in_sel = s; in_data = d; out_ready = r; err_clr = c;
    #1;
    ones = $countones(s);
    k = 0;
    for (int j = 0; j < N; j++) if (s[j]) k = j;
    exp_rdy = (ones == 1) ? (!m_full[k] || r[k]) : 1'b1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
    for (int j = 0; j < N; j++) if (m_full[j] && r[j]) m_full[j] = 0;
    if (v && ones == 1 && exp_rdy) begin
      m_full[k] = 1;
      m_data[k] = int'(d);
    end
    if (v && ones != 1) begin
      m_err = 1;
      m_cnt = c ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (c) begin
      m_err = 0;
      m_cnt = 0;
    end
    check_outputs(tag);
  endtask

  initial begin
    logic [N-1:0] s;
    reset = 1'b1; in_valid = 0; in_sel = '0; in_data = '0; out_ready = '0; err_clr = 0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single beat, then pop.
    step("single", 1, 4'b0100, 8'hA5, 4'b1111, 0);
    step("single_pop", 0, 4'b0000, 8'h00, 4'b1111, 0);

    // Stall isolation on port 1.
    step("stall_a", 1, 4'b0010, 8'h11, 4'b1101, 0);
    step("stall_b", 1, 4'b0010, 8'h22, 4'b1101, 0);
    step("stall_c", 1, 4'b1000, 8'h33, 4'b1101, 0);
    step("stall_d", 1, 4'b0010, 8'h22, 4'b1111, 0);
    step("stall_e", 0, 4'b0000, 8'h00, 4'b1111, 0);

    // Full-rate rotation.
    for (int i = 0; i < 16; i++)
      step("stream", 1, 4'b0001 << (i % 4), 8'(i), 4'b1111, 0);

    // Malformed selects, saturation and clear behaviour.
    step("mal0", 1, 4'b0000, 8'h5A, 4'b1111, 0);
    step("mal6", 1, 4'b0110, 8'h5B, 4'b1111, 0);
    check("mal_cnt2", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 300; i++)
      step("sat", 1, (i % 2) ? 4'b1111 : 4'b0000, 8'(i), 4'b1111, 0);
    check("sat_255", 64'(drop_cnt), 64'd255);
    step("clr", 0, 4'b0000, 8'h00, 4'b1111, 1);
    step("clr_drop", 1, 4'b0011, 8'h00, 4'b1111, 1);

    // Random traffic with occasional malformed selects and clears.
    for (int i = 0; i < 600; i++) begin
      s = ($urandom_range(0, 7) == 0) ? N'($urandom) : (N'(1) << $urandom_range(0, N-1));
      step("rand", 1'($urandom_range(0, 3) != 0), s, 8'($urandom),
           N'($urandom) | N'($urandom), 1'($urandom_range(0, 19) == 0));
    end

    // Stalled beats on ports 0 and 2 plus a set err, then asynchronous reset.
    step("pre_a", 1, 4'b0001, 8'hC0, 4'b0000, 0);
    step("pre_b", 1, 4'b0100, 8'hC2, 4'b0000, 0);
    step("pre_c", 1, 4'b1100, 8'hEE, 4'b0000, 0);
    in_valid = 0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step("post_rst", 1, 4'b0001, 8'h77, 4'b0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
